// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package ifetch_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_SEQ      = 2'd1,
        PC_REDIRECT = 2'd2,
        PC_TARGET   = 2'd3
    } pc_sel_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_next_pc.sv
// Next fetch-address selection: hold, sequential step, live redirect or latched target.
module ifetch_next_pc
    import ifetch_pkg::*;
(
    input  logic [31:0] fetch_pc,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] target_pc,
    input  pc_sel_e     sel,
    output logic [31:0] next_pc
);

    always_comb begin
        next_pc = fetch_pc;
        unique case (sel)
            PC_HOLD:     next_pc = fetch_pc;
            PC_SEQ:      next_pc = fetch_pc + PC_STEP;
            PC_REDIRECT: next_pc = align_pc(redirect_pc);
            PC_TARGET:   next_pc = target_pc;
            default:     next_pc = fetch_pc;
        endcase
    end

endmodule

// File: rtl/ifetch_unit.sv
// Single-outstanding instruction fetch FSM with redirect/kill handling and a held output stage.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  target_q, target_d;
    logic         kill_q, kill_d;
    logic [31:0]  instr_q, pc_q;
    logic         capture;
    pc_sel_e      pc_sel;

    ifetch_next_pc u_next_pc (
        .fetch_pc    (fetch_pc_q),
        .redirect_pc (redirect_pc),
        .target_pc   (target_q),
        .sel         (pc_sel),
        .next_pc     (fetch_pc_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    state_d = S_REQ;
                end else if (imem_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = (redirect_valid || kill_q) ? S_REQ : S_VALID;
                end
            end
            S_VALID: begin
                if (redirect_valid || !stall) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // A redirect while a read is in flight cannot cancel the memory access, so the
    // target is parked and the returning word is dropped when it arrives.
    always_comb begin
        pc_sel   = PC_HOLD;
        capture  = 1'b0;
        kill_d   = kill_q;
        target_d = target_q;
        unique case (state_q)
            S_REQ: begin
                if (redirect_valid) pc_sel = PC_REDIRECT;
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    if (imem_rvalid) begin
                        pc_sel = PC_REDIRECT;
                        kill_d = 1'b0;
                    end else begin
                        target_d = align_pc(redirect_pc);
                        kill_d   = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (kill_q) begin
                        pc_sel = PC_TARGET;
                        kill_d = 1'b0;
                    end else begin
                        capture = 1'b1;
                    end
                end
            end
            S_VALID: begin
                if (redirect_valid) begin
                    pc_sel = PC_REDIRECT;
                end else if (!stall) begin
                    pc_sel = PC_SEQ;
                end
            end
            default: pc_sel = PC_HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            target_q   <= RESET_PC;
            kill_q     <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_q       <= 32'h0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            target_q   <= target_d;
            kill_q     <= kill_d;
            if (capture) begin
                instr_q <= imem_rdata;
                pc_q    <= fetch_pc_q;
            end
        end
    end

    always_comb begin
        imem_req    = (state_q == S_REQ) && !rst;
        imem_addr   = fetch_pc_q;
        instr_valid = (state_q == S_VALID);
        instr_out   = instr_valid ? instr_q : NOP_INSTR;
        pc_out      = instr_valid ? pc_q : 32'h0;
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed scenarios plus a randomized run against a transaction-level fetch model.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;

    int n_vec = 0;
    int n_err = 0;

    ifetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .instr_valid    (instr_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    endtask

    // From S_REQ: accept, return data next cycle, land in S_VALID.
    task automatic go_valid(input logic [31:0] data);
        imem_ready = 1'b1; tick();
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = data; tick();
        imem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_vec++; if (instr_out !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", instr_out); end
        n_vec++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", pc_out); end
    endtask

    task automatic test_basic();
        rst = 1'b0; #1;
        n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL basic_req1: got %b want 1", imem_req); end
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL basic_addr1: got %h want 0", imem_addr); end
        imem_ready = 1'b1; tick();
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL basic_req2: got %b want 0", imem_req); end
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2008_0005; tick();
        imem_rvalid = 1'b0;
        n_vec++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid3: got %b want 1", instr_valid); end
        n_vec++; if (instr_out !== 32'h2008_0005) begin n_err++; $display("FAIL basic_instr3: got %h want 20080005", instr_out); end
        n_vec++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL basic_pc3: got %h want 0", pc_out); end
        tick();
        n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL basic_req4: got %b want 1", imem_req); end
        n_vec++; if (imem_addr !== 32'h4) begin n_err++; $display("FAIL basic_addr4: got %h want 4", imem_addr); end
    endtask

    task automatic test_stall();
        go_valid(32'h1234_5678);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want 1", i, instr_valid); end
            n_vec++; if (instr_out !== 32'h1234_5678) begin n_err++; $display("FAIL stall_instr[%0d]: got %h want 12345678", i, instr_out); end
            n_vec++; if (pc_out !== 32'h4) begin n_err++; $display("FAIL stall_pc[%0d]: got %h want 4", i, pc_out); end
            n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req[%0d]: got %b want 0", i, imem_req); end
            tick();
        end
        stall = 1'b0;
        n_vec++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL stall_hold_end: got %b want 1", instr_valid); end
        tick();
        n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL stall_next_req: got %b want 1", imem_req); end
        n_vec++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL stall_next_addr: got %h want 8", imem_addr); end
    endtask

    task automatic test_ready_low();
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rdylow_req[%0d]: got %b want 1", i, imem_req); end
            n_vec++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL rdylow_addr[%0d]: got %h want 8", i, imem_addr); end
            tick();
        end
        imem_ready = 1'b1; tick();
        imem_ready = 1'b0;
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rdylow_accept: got %b want 0", imem_req); end
    endtask

    task automatic test_redirect_wait();
        // DUT is in S_WAIT with the request for 8 outstanding
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; tick();
        redirect_valid = 1'b0;
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rdw_valid_a: got %b want 0", instr_valid); end
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rdw_req_a: got %b want 0", imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; tick();
        imem_rvalid = 1'b0;
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rdw_valid_b: got %b want 0", instr_valid); end
        n_vec++; if (imem_addr !== 32'h0000_0100) begin n_err++; $display("FAIL rdw_addr: got %h want 00000100", imem_addr); end
        n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rdw_req_b: got %b want 1", imem_req); end
        // redirect and rvalid in the same S_WAIT cycle
        imem_ready = 1'b1; tick();
        imem_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0202; imem_rvalid = 1'b1; tick();
        redirect_valid = 1'b0; imem_rvalid = 1'b0;
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rdsame_valid: got %b want 0", instr_valid); end
        n_vec++; if (imem_addr !== 32'h0000_0200) begin n_err++; $display("FAIL rdsame_addr: got %h want 00000200", imem_addr); end
        // two redirects while killed: last one wins
        imem_ready = 1'b1; tick();
        imem_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0300; tick();
        redirect_pc = 32'h0000_0405; tick();
        redirect_valid = 1'b0; imem_rvalid = 1'b1; tick();
        imem_rvalid = 1'b0;
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rd2_valid: got %b want 0", instr_valid); end
        n_vec++; if (imem_addr !== 32'h0000_0404) begin n_err++; $display("FAIL rd2_addr: got %h want 00000404", imem_addr); end
        // stray rvalid in S_REQ
        imem_rvalid = 1'b1; imem_rdata = 32'h5555_AAAA; tick();
        imem_rvalid = 1'b0;
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL stray_valid: got %b want 0", instr_valid); end
        n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL stray_req: got %b want 1", imem_req); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; tick();
        redirect_valid = 1'b0;
        n_vec++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr_a: got %h want fffffffc", imem_addr); end
        go_valid(32'hCAFE_0001);
        n_vec++; if (pc_out !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc: got %h want fffffffc", pc_out); end
        tick();
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr_b: got %h want 0", imem_addr); end
    endtask

    task automatic test_redirect_stall();
        go_valid(32'h0BAD_F00D);
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0050; tick();
        stall = 1'b0; redirect_valid = 1'b0;
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rdst_valid: got %b want 0", instr_valid); end
        n_vec++; if (instr_out !== 32'h0) begin n_err++; $display("FAIL rdst_instr: got %h want 0", instr_out); end
        n_vec++; if (imem_addr !== 32'h0000_0050) begin n_err++; $display("FAIL rdst_addr: got %h want 00000050", imem_addr); end
    endtask

    task automatic test_reset_mid();
        imem_ready = 1'b1; tick();
        imem_ready = 1'b0;
        rst = 1'b1; tick();
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rmid_req: got %b want 0", imem_req); end
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b want 0", instr_valid); end
        rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0BAD; #1;
        n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rmid_req2: got %b want 1", imem_req); end
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rmid_addr: got %h want 0", imem_addr); end
        tick();
        imem_rvalid = 1'b0;
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rmid_stale: got %b want 0", instr_valid); end
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rmid_addr2: got %h want 0", imem_addr); end
    endtask

    // Transaction-level model: one request in flight or one instruction held, never both.
    task automatic test_random();
        logic [31:0] exp_fetch = 32'h0;
        logic [31:0] out_addr  = 32'h0;
        logic [31:0] cur_pc    = 32'h0;
        logic [31:0] cur_instr = 32'h0;
        bit outstanding = 0, killed = 0, holding = 0, req_now;
        int mem_wait = 0;
        idle_inputs();
        rst = 1'b1; tick(); tick();
        rst = 1'b0; #1;
        for (int c = 0; c < 3000; c++) begin
            req_now = !outstanding && !holding;
            n_vec++; if (imem_req !== req_now) begin n_err++; $display("FAIL rnd_req@%0d: got %b want %b", c, imem_req, req_now); end
            if (req_now) begin
                n_vec++; if (imem_addr !== exp_fetch) begin n_err++; $display("FAIL rnd_addr@%0d: got %h want %h", c, imem_addr, exp_fetch); end
            end
            n_vec++; if (instr_valid !== holding) begin n_err++; $display("FAIL rnd_valid@%0d: got %b want %b", c, instr_valid, holding); end
            n_vec++; if (instr_out !== (holding ? cur_instr : 32'h0)) begin n_err++; $display("FAIL rnd_instr@%0d: got %h want %h", c, instr_out, holding ? cur_instr : 32'h0); end
            n_vec++; if (pc_out !== (holding ? cur_pc : 32'h0)) begin n_err++; $display("FAIL rnd_pc@%0d: got %h want %h", c, pc_out, holding ? cur_pc : 32'h0); end

            stall          = ($urandom % 3) == 0;
            redirect_valid = ($urandom % 10) == 0;
            redirect_pc    = $urandom;
            imem_ready     = (($urandom % 3) != 0) && !(redirect_valid && req_now);
            imem_rdata     = $urandom;
            if (outstanding && mem_wait == 0) begin
                imem_rvalid = 1'b1;
            end else begin
                imem_rvalid = ($urandom % 8) == 0;
                if (outstanding) mem_wait--;
            end

            if (redirect_valid) begin
                exp_fetch = {redirect_pc[31:2], 2'b00};
                holding   = 0;
                if (outstanding) begin
                    killed = 1;
                    if (imem_rvalid) outstanding = 0;
                end
            end else if (holding && !stall) begin
                holding   = 0;
                exp_fetch = exp_fetch + 32'd4;
            end else if (outstanding && imem_rvalid) begin
                outstanding = 0;
                if (!killed) begin
                    holding   = 1;
                    cur_pc    = out_addr;
                    cur_instr = imem_rdata;
                end
            end
            if (req_now && imem_ready) begin
                outstanding = 1;
                killed      = 0;
                out_addr    = exp_fetch;
                mem_wait    = $urandom_range(0, 2);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_ready_low();
        test_redirect_wait();
        test_wrap();
        test_redirect_stall();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
